// File: rtl/lca_axi_pkg.sv
// Shared types and AXI encodings for the LCA read master.
package lca_axi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // EXOKAY is flagged too: this master never issues exclusive reads.
  function automatic logic resp_is_err(logic [1:0] resp);
    return (resp == AXI_RESP_EXOKAY) || (resp == AXI_RESP_SLVERR) ||
           (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/lca_rd_fifo.sv
// Synchronous beat FIFO; pointers carry an extra MSB to tell full from empty.
module lca_rd_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  // Zero when empty so the stream output has a defined reset value.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];

endmodule

// File: rtl/lca_axi_rd_master.sv
// Single-command AXI4 INCR burst reader feeding a valid/ready stream through a small FIFO.
// Define LCA_AXI_RD_ERR_EN to get a sticky err_o on non-OKAY read responses.
module lca_axi_rd_master
  import lca_axi_pkg::*;
#(
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter int unsigned                AXI_DATA_WIDTH = 32,
  parameter int unsigned                AXI_ID_WIDTH   = 2,
  parameter int unsigned                AXI_USER_WIDTH = 1,
  parameter logic [AXI_ID_WIDTH-1:0]    AXI_ID         = 2'b11,
  parameter int unsigned                FIFO_DEPTH     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [7:0]                  cmd_len_i,
  output logic                        data_valid_o,
  input  logic                        data_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   data_o,
  output logic                        data_last_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [7:0]                  ar_len_o,
  output logic [2:0]                  ar_size_o,
  output logic [1:0]                  ar_burst_o,
  output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
  output logic [2:0]                  ar_prot_o,
  output logic [3:0]                  ar_cache_o,
  output logic                        ar_lock_o,
  output logic [3:0]                  ar_qos_o,
  output logic [3:0]                  ar_region_o,
  output logic [AXI_USER_WIDTH-1:0]   ar_user_o,
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   r_user_i,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [7:0]                  aw_len_o,
  output logic [2:0]                  aw_size_o,
  output logic [1:0]                  aw_burst_o,
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic [2:0]                  aw_prot_o,
  output logic [3:0]                  aw_cache_o,
  output logic                        aw_lock_o,
  output logic [3:0]                  aw_qos_o,
  output logic [3:0]                  aw_region_o,
  output logic [AXI_USER_WIDTH-1:0]   aw_user_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  output logic [AXI_USER_WIDTH-1:0]   w_user_o,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [1:0]                  b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   b_user_i,
  output logic                        busy_o,
  output logic                        err_o
);

  rd_state_e                 state_q;
  logic                      cmd_ready_q, ar_valid_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic                      cmd_accept, r_push, fifo_full, fifo_empty;

  assign cmd_accept = (state_q == StIdle) && cmd_valid_i && cmd_ready_q;
  assign r_push     = r_valid_i && r_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      ar_valid_q  <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_accept) begin
            addr_q      <= {cmd_addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};
            len_q       <= cmd_len_i;
            cmd_ready_q <= 1'b0;
            ar_valid_q  <= 1'b1;
            state_q     <= StAddr;
          end
        end
        StAddr: begin
          if (ar_ready_i) begin
            ar_valid_q <= 1'b0;
            state_q    <= StData;
          end
        end
        StData: begin
          if (r_push && r_last_i) begin
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready depends only on full, so a pop from full never admits a push that cycle.
  assign r_ready_o = (state_q == StData) && !fifo_full;

  lca_rd_fifo #(
    .Width (AXI_DATA_WIDTH + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (r_push),
    .wdata_i ({r_data_i, r_last_i}),
    .pop_i   (data_ready_i),
    .rdata_o ({data_o, data_last_o}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign data_valid_o = !fifo_empty;
  assign cmd_ready_o  = cmd_ready_q;
  assign busy_o       = (state_q != StIdle) || !fifo_empty;

  assign ar_valid_o  = ar_valid_q;
  assign ar_addr_o   = addr_q;
  assign ar_len_o    = len_q;
  assign ar_size_o   = AXI_SIZE_4B;
  assign ar_burst_o  = AXI_BURST_INCR;
  assign ar_id_o     = AXI_ID;
  assign ar_prot_o   = '0;
  assign ar_cache_o  = '0;
  assign ar_lock_o   = 1'b0;
  assign ar_qos_o    = '0;
  assign ar_region_o = '0;
  assign ar_user_o   = '0;

  assign aw_valid_o  = 1'b0;
  assign aw_addr_o   = '0;
  assign aw_len_o    = '0;
  assign aw_size_o   = '0;
  assign aw_burst_o  = '0;
  assign aw_id_o     = '0;
  assign aw_prot_o   = '0;
  assign aw_cache_o  = '0;
  assign aw_lock_o   = 1'b0;
  assign aw_qos_o    = '0;
  assign aw_region_o = '0;
  assign aw_user_o   = '0;
  assign w_valid_o   = 1'b0;
  assign w_data_o    = '0;
  assign w_strb_o    = '0;
  assign w_last_o    = 1'b0;
  assign w_user_o    = '0;
  assign b_ready_o   = 1'b1;

`ifdef LCA_AXI_RD_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (cmd_accept) begin
      err_q <= 1'b0;
    end else if (r_push && resp_is_err(r_resp_i)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  logic unused_inputs;
  assign unused_inputs = ^{cmd_addr_i[1:0], r_id_i, r_user_i, aw_ready_i, w_ready_i,
                           b_valid_i, b_resp_i, b_id_i, b_user_i};
`else
  assign err_o = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{cmd_addr_i[1:0], r_id_i, r_user_i, r_resp_i, aw_ready_i,
                           w_ready_i, b_valid_i, b_resp_i, b_id_i, b_user_i};
`endif

endmodule

// File: tb/tb_lca_axi_rd_master.sv
// Directed bench for lca_axi_rd_master; expected stream beats are queued as R beats are accepted.
module tb_lca_axi_rd_master;
  import lca_axi_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 2;
  localparam int UW    = 1;
  localparam int DEPTH = 4;
`ifdef LCA_AXI_RD_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic cmd_valid_i, cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic [7:0] cmd_len_i;
  logic data_valid_o, data_ready_i, data_last_o;
  logic [DW-1:0] data_o;
  logic ar_valid_o, ar_ready_i, ar_lock_o;
  logic [AW-1:0] ar_addr_o;
  logic [7:0] ar_len_o;
  logic [2:0] ar_size_o, ar_prot_o;
  logic [1:0] ar_burst_o;
  logic [IW-1:0] ar_id_o;
  logic [3:0] ar_cache_o, ar_qos_o, ar_region_o;
  logic [UW-1:0] ar_user_o;
  logic r_valid_i, r_ready_o, r_last_i;
  logic [DW-1:0] r_data_i;
  logic [1:0] r_resp_i;
  logic [IW-1:0] r_id_i;
  logic [UW-1:0] r_user_i;
  logic aw_valid_o, aw_ready_i, aw_lock_o;
  logic [AW-1:0] aw_addr_o;
  logic [7:0] aw_len_o;
  logic [2:0] aw_size_o, aw_prot_o;
  logic [1:0] aw_burst_o;
  logic [IW-1:0] aw_id_o;
  logic [3:0] aw_cache_o, aw_qos_o, aw_region_o;
  logic [UW-1:0] aw_user_o, w_user_o, b_user_i;
  logic w_valid_o, w_ready_i, w_last_o;
  logic [DW-1:0] w_data_o;
  logic [DW/8-1:0] w_strb_o;
  logic b_valid_i, b_ready_o;
  logic [1:0] b_resp_i;
  logic [IW-1:0] b_id_i;
  logic busy_o, err_o;

  always #5 clk_i = ~clk_i;

  lca_axi_rd_master dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .cmd_valid_i (cmd_valid_i), .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i (cmd_addr_i), .cmd_len_i (cmd_len_i),
    .data_valid_o (data_valid_o), .data_ready_i (data_ready_i),
    .data_o (data_o), .data_last_o (data_last_o),
    .ar_valid_o (ar_valid_o), .ar_ready_i (ar_ready_i), .ar_addr_o (ar_addr_o),
    .ar_len_o (ar_len_o), .ar_size_o (ar_size_o), .ar_burst_o (ar_burst_o),
    .ar_id_o (ar_id_o), .ar_prot_o (ar_prot_o), .ar_cache_o (ar_cache_o),
    .ar_lock_o (ar_lock_o), .ar_qos_o (ar_qos_o), .ar_region_o (ar_region_o),
    .ar_user_o (ar_user_o),
    .r_valid_i (r_valid_i), .r_ready_o (r_ready_o), .r_data_i (r_data_i),
    .r_resp_i (r_resp_i), .r_last_i (r_last_i), .r_id_i (r_id_i), .r_user_i (r_user_i),
    .aw_valid_o (aw_valid_o), .aw_ready_i (aw_ready_i), .aw_addr_o (aw_addr_o),
    .aw_len_o (aw_len_o), .aw_size_o (aw_size_o), .aw_burst_o (aw_burst_o),
    .aw_id_o (aw_id_o), .aw_prot_o (aw_prot_o), .aw_cache_o (aw_cache_o),
    .aw_lock_o (aw_lock_o), .aw_qos_o (aw_qos_o), .aw_region_o (aw_region_o),
    .aw_user_o (aw_user_o),
    .w_valid_o (w_valid_o), .w_ready_i (w_ready_i), .w_data_o (w_data_o),
    .w_strb_o (w_strb_o), .w_last_o (w_last_o), .w_user_o (w_user_o),
    .b_valid_i (b_valid_i), .b_ready_o (b_ready_o), .b_resp_i (b_resp_i),
    .b_id_i (b_id_i), .b_user_i (b_user_i),
    .busy_o (busy_o), .err_o (err_o)
  );

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];
  logic cmd_hs, ar_hs, r_hs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes and score stream beats at negedge, return 1 after posedge.
  task automatic step();
    logic [DW:0] want;
    @(negedge clk_i);
    cmd_hs = cmd_valid_i && cmd_ready_o;
    ar_hs  = ar_valid_o && ar_ready_i;
    r_hs   = r_valid_i && r_ready_o && !rst_i;
    if (!rst_i && data_valid_o && data_ready_i) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("stream_beat", {data_o, data_last_o}, want);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_burst(input logic [31:0] addr, input int len, input int err_beat,
                          input int ar_stall, input bit bp, input int rst_beat,
                          input bit thru);
    logic [31:0] exp_addr;
    int budget, cycles, stalled;
    exp_addr = {addr[31:2], 2'b00};
    check("ar_4k_boundary", ((exp_addr & 32'hfff) + (len + 1) * 4) <= 4096, 1);
    cmd_addr_i  = addr;
    cmd_len_i   = len[7:0];
    cmd_valid_i = 1'b1;
    budget = 0;
    cmd_hs = 1'b0;
    while (!cmd_hs && budget < 20) begin step(); budget++; end
    cmd_valid_i = 1'b0;
    check("cmd_accept", cmd_hs, 1);
    if (!cmd_hs) return;
    check("ar_fields", {ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o},
          {1'b1, exp_addr, len[7:0], 3'b010, 2'b01, 2'b11});
    check("accept_side", {cmd_ready_o, busy_o, err_o, r_ready_o}, 4'b0100);
    for (int c = 0; c < ar_stall; c++) begin
      step();
      check("ar_stall_hold", {ar_valid_o, ar_addr_o, ar_len_o, cmd_ready_o},
            {1'b1, exp_addr, len[7:0], 1'b0});
    end
    ar_ready_i = 1'b1;
    budget = 0;
    ar_hs = 1'b0;
    while (!ar_hs && budget < 20) begin step(); budget++; end
    ar_ready_i = 1'b0;
    check("ar_handshake", {ar_hs, ar_valid_o}, 2'b10);
    cycles = 0;
    for (int i = 0; i <= len; i++) begin
      r_data_i  = $urandom;
      r_last_i  = (i == len);
      r_resp_i  = (i == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      r_id_i    = 2'b01;
      r_user_i  = 1'b1;
      r_valid_i = 1'b1;
      if (i == rst_beat) begin
        rst_i = 1'b1;
        step();
        check("reset_mid_burst", {ar_valid_o, r_ready_o, data_valid_o, data_o, data_last_o,
                                  busy_o, err_o, cmd_ready_o}, '0);
        r_valid_i = 1'b0;
        rst_i = 1'b0;
        exp_q.delete();
        step();
        check("post_reset", {data_valid_o, cmd_ready_o, busy_o}, 3'b010);
        return;
      end
      budget = 0;
      stalled = 0;
      r_hs = 1'b0;
      while (!r_hs && budget < 100) begin
        step();
        budget++;
        cycles++;
        if (!r_hs) begin
          stalled++;
          if (bp && stalled == 5) begin
            check("bp_full", {r_ready_o, 8'(i)}, {1'b0, 8'(DEPTH)});
            data_ready_i = 1'b1;
          end
        end
      end
      check("r_beat_accept", r_hs, 1);
      if (!r_hs) begin
        r_valid_i = 1'b0;
        return;
      end
      exp_q.push_back({r_data_i, r_last_i});
      if (i == err_beat) check("err_set", err_o, ErrEn);
    end
    r_valid_i = 1'b0;
    if (thru) check("throughput_cycles", cycles, len + 1);
    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin step(); budget++; end
    check("drained", exp_q.size(), 0);
    check("idle_after", {busy_o, data_valid_o, cmd_ready_o}, 3'b001);
  endtask

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    data_ready_i = 1'b1; ar_ready_i = 1'b0;
    r_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0; r_last_i = 1'b0;
    r_id_i = '0; r_user_i = '0;
    aw_ready_i = 1'b0; w_ready_i = 1'b0;
    b_valid_i = 1'b0; b_resp_i = '0; b_id_i = '0; b_user_i = '0;
    repeat (3) step();
    check("reset_state", {cmd_ready_o, ar_valid_o, r_ready_o, data_valid_o, data_o,
                          data_last_o, busy_o, err_o}, '0);
    rst_i = 1'b0;
    step();
    check("ready_after_reset", {cmd_ready_o, busy_o, aw_valid_o, w_valid_o, b_ready_o},
          5'b10001);

    do_burst(32'h0010_0104, 0, -1, 0, 1'b0, -1, 1'b0);
    do_burst(32'h0010_0007, 3, -1, 0, 1'b0, -1, 1'b1);
    data_ready_i = 1'b0;
    do_burst(32'h0020_0000, 15, -1, 0, 1'b1, -1, 1'b0);
    data_ready_i = 1'b1;
    do_burst(32'h0030_0ff8, 1, -1, 10, 1'b0, -1, 1'b0);
    do_burst(32'h0040_0100, 3, 1, 0, 1'b0, -1, 1'b0);
    repeat (3) step();
    check("err_sticky", err_o, ErrEn);
    do_burst(32'h0050_0200, 7, -1, 0, 1'b0, 4, 1'b0);
    do_burst(32'h0050_0200, 7, -1, 0, 1'b0, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
